// File: rtl/spectrum_pkg.sv
// Shared spectrum constants: FFT frame geometry, sample and magnitude widths,
// and the field offsets of the real/imag components inside an FFT tdata beat.
// Used by fft_to_bram, bram_to_fft and the note detector.
package spectrum_pkg;

   localparam int unsigned LOG_N  = 12;
   localparam int unsigned N      = 2 ** LOG_N;
   localparam int unsigned CW     = 16;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned SHIFT  = 14;

   // tdata layout: {imag, real}
   localparam int unsigned RE_LSB = 0;
   localparam int unsigned IM_LSB = CW;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage magnitude-squared unit: squares re/im, sums, shifts right by SHIFT
// and saturates to OUT_W. A tag travels alongside the data and reads as zero
// on cycles where no valid beat is present, so its flag bits can drive strobes.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   in_valid_i  beat present on re_i/im_i/tag_i
//   re_i, im_i  signed components
//   tag_i       sideband carried with the beat
//   mag_o       saturated scaled re^2+im^2 (holds between beats)
//   tag_o       sideband two cycles later, zero when no beat
module mag_sq_pipe #(
   parameter int unsigned CW    = 16,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 14,
   parameter int unsigned TW    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   input  logic signed [CW-1:0] re_i,
   input  logic signed [CW-1:0] im_i,
   input  logic [TW-1:0]        tag_i,
   output logic [OUT_W-1:0]     mag_o,
   output logic [TW-1:0]        tag_o
);

   localparam int unsigned PW = 2 * CW;
   localparam int unsigned SW = 2 * CW + 1;

   logic                 v1_q;
   logic signed [PW-1:0] re2_q;
   logic signed [PW-1:0] im2_q;
   logic [TW-1:0]        tag1_q;
   logic [OUT_W-1:0]     mag_q;
   logic [TW-1:0]        tag2_q;

   logic [SW-1:0]        sum_c;
   logic [SW-1:0]        shr_c;
   logic [OUT_W-1:0]     sat_c;

   // Squares are non-negative, so the sum is treated as unsigned with one carry bit.
   always_comb begin
      sum_c = SW'($unsigned(re2_q)) + SW'($unsigned(im2_q));
      shr_c = sum_c >> SHIFT;
      sat_c = (|shr_c[SW-1:OUT_W]) ? '1 : shr_c[OUT_W-1:0];
   end

   // Stage 1: products. Stage 2: shift/saturate result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         re2_q  <= '0;
         im2_q  <= '0;
         tag1_q <= '0;
         mag_q  <= '0;
         tag2_q <= '0;
      end else begin
         v1_q   <= in_valid_i;
         tag1_q <= in_valid_i ? tag_i : '0;
         if (in_valid_i) begin
            re2_q <= PW'(re_i) * PW'(re_i);
            im2_q <= PW'(im_i) * PW'(im_i);
         end
         tag2_q <= v1_q ? tag1_q : '0;
         if (v1_q) begin
            mag_q <= sat_c;
         end
      end
   end

   assign mag_o = mag_q;
   assign tag_o = tag2_q;

endmodule

// File: rtl/fft_to_bram.sv
// Writes the lower half of each 4096-bin FFT output frame into a double-buffered
// spectrum BRAM as saturated magnitude-squared words, checks tlast framing, and
// flips the published bank on every clean frame.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   s_tdata          FFT beat {imag, real}, two's complement
//   s_tvalid/s_tlast FFT beat valid / final beat of frame
//   s_tready         high from the second cycle after reset release onward
//   wr_addr/wr_data  BRAM write port, address = {write bank, bin}
//   wr_en            BRAM write strobe
//   rd_bank          bank holding the latest complete spectrum
//   frame_valid      a complete spectrum has been published since reset
//   frame_done       pulse when rd_bank updates
//   err_unexpected   pulse: tlast before the final bin
//   err_missing      pulse: final bin without tlast
module fft_to_bram #(
   parameter int unsigned LOG_N = spectrum_pkg::LOG_N,
   parameter int unsigned CW    = spectrum_pkg::CW,
   parameter int unsigned OUT_W = spectrum_pkg::OUT_W,
   parameter int unsigned SHIFT = spectrum_pkg::SHIFT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*CW-1:0]    s_tdata,
   input  logic               s_tvalid,
   input  logic               s_tlast,
   output logic               s_tready,
   output logic [LOG_N-1:0]   wr_addr,
   output logic [OUT_W-1:0]   wr_data,
   output logic               wr_en,
   output logic               rd_bank,
   output logic               frame_valid,
   output logic               frame_done,
   output logic               err_unexpected,
   output logic               err_missing
);

   import spectrum_pkg::*;

   // Sideband carried through the magnitude pipe alongside each beat.
   typedef struct packed {
      logic             keep;
      logic             done;
      logic             err_u;
      logic             err_m;
      logic             bank;
      logic [LOG_N-2:0] bin;
   } tag_t;

   localparam int unsigned TW = $bits(tag_t);

   logic                 rst_seen_q;
   logic                 ready_q;
   logic [LOG_N-1:0]     cnt_q, cnt_d;
   logic                 bank_q, bank_d;
   logic                 s0_valid_q;
   logic signed [CW-1:0] s0_re_q;
   logic signed [CW-1:0] s0_im_q;
   tag_t                 s0_tag_q, tag_d;
   logic                 s1_done_q;
   logic                 s1_bank_q;
   logic                 rd_bank_q;
   logic                 frame_valid_q;

   logic                 accept_c;
   logic                 last_bin_c;
   tag_t                 out_tag;

   // Bin counter, framing classification and front-end write bank. The bank
   // flips at the accept of a clean final beat, so the next frame's beats
   // already carry the new bank while the old frame drains.
   always_comb begin
      accept_c   = s_tvalid & ready_q;
      last_bin_c = &cnt_q;
      cnt_d      = cnt_q;
      bank_d     = bank_q;
      tag_d      = s0_tag_q;
      if (accept_c) begin
         cnt_d       = (s_tlast | last_bin_c) ? '0 : cnt_q + LOG_N'(1);
         bank_d      = (s_tlast & last_bin_c) ? ~bank_q : bank_q;
         tag_d.keep  = ~cnt_q[LOG_N-1];
         tag_d.done  = s_tlast & last_bin_c;
         tag_d.err_u = s_tlast & ~last_bin_c;
         tag_d.err_m = ~s_tlast & last_bin_c;
         tag_d.bank  = bank_q;
         tag_d.bin   = cnt_q[LOG_N-2:0];
      end
   end

   // Stage 0 capture, ready generation and publish bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_seen_q    <= 1'b0;
         ready_q       <= 1'b0;
         cnt_q         <= '0;
         bank_q        <= 1'b0;
         s0_valid_q    <= 1'b0;
         s0_re_q       <= '0;
         s0_im_q       <= '0;
         s0_tag_q      <= '0;
         s1_done_q     <= 1'b0;
         s1_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b1;
         frame_valid_q <= 1'b0;
      end else begin
         rst_seen_q <= 1'b1;
         ready_q    <= rst_seen_q;
         cnt_q      <= cnt_d;
         bank_q     <= bank_d;
         s0_valid_q <= accept_c;
         s0_tag_q   <= tag_d;
         if (accept_c) begin
            s0_re_q <= s_tdata[RE_LSB +: CW];
            s0_im_q <= s_tdata[IM_LSB +: CW];
         end
         // Shadow of the pipe's stage 1 so the bank flips on the frame_done edge.
         s1_done_q <= s0_valid_q & s0_tag_q.done;
         s1_bank_q <= s0_tag_q.bank;
         if (s1_done_q) begin
            rd_bank_q     <= s1_bank_q;
            frame_valid_q <= 1'b1;
         end
      end
   end

   mag_sq_pipe #(
      .CW    (CW),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .TW    (TW)
   ) u_mag (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (s0_valid_q),
      .re_i       (s0_re_q),
      .im_i       (s0_im_q),
      .tag_i      (s0_tag_q),
      .mag_o      (wr_data),
      .tag_o      (out_tag)
   );

   assign s_tready       = ready_q;
   assign wr_en          = out_tag.keep;
   assign wr_addr        = {out_tag.bank, out_tag.bin};
   assign frame_done     = out_tag.done;
   assign err_unexpected = out_tag.err_u;
   assign err_missing    = out_tag.err_m;
   assign rd_bank        = rd_bank_q;
   assign frame_valid    = frame_valid_q;

endmodule
